// File: rtl/scope_fb_pkg.sv
// Shared types and constants for the scope frame buffer: clear FSM encoding,
// base read latency and bank-count helper.
package scope_fb_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  localparam int RD_LAT_BASE = 1;

  function automatic int bank_count(input int bank_w);
    return 1 << bank_w;
  endfunction

endpackage

// File: rtl/scope_fb_clear_fsm.sv
// Clear engine: sweeps every word to CLEAR_VAL and owns the write port while busy,
// dropping external writes for the duration of the sweep.
module scope_fb_clear_fsm
  import scope_fb_pkg::*;
#(
  parameter int                ADDR_W    = 15,
  parameter int                DATA_W    = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data
);

  clr_state_t        state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLR_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    mem_we   = wr_en;
    mem_addr = wr_addr;
    mem_data = wr_data;
    unique case (state)
      CLR_IDLE: begin
        cnt_nx = '0;
        if (clr_req) state_nx = CLR_SWEEP;
      end
      CLR_SWEEP: begin
        clr_busy = 1'b1;
        mem_we   = 1'b1;
        mem_addr = cnt;
        mem_data = CLEAR_VAL;
        cnt_nx   = cnt + 1'b1;
        if (&cnt) state_nx = CLR_DONE;
      end
      CLR_DONE: begin
        clr_done = 1'b1;
        state_nx = CLR_IDLE;
      end
      default: state_nx = CLR_IDLE;
    endcase
  end

endmodule

// File: rtl/scope_frame_ram.sv
// Banked single-clock frame buffer with registered bank mux, optional output register
// and hardware clear. SCOPE_FRAME_RAM_DBUF_EN adds a second page with front/back swap.
module scope_frame_ram
  import scope_fb_pkg::*;
#(
  parameter int                DATA_W    = 1,
  parameter int                ADDR_W    = 15,
  parameter int                BANK_W    = 1,
  parameter int                OUT_REG   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_oce,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              clr_busy,
`ifdef SCOPE_FRAME_RAM_DBUF_EN
  input  logic              swap_req,
  output logic              front_page,
`endif
  output logic              clr_done
);

  localparam int NB     = bank_count(BANK_W);
  localparam int LO_W   = ADDR_W - BANK_W;
`ifdef SCOPE_FRAME_RAM_DBUF_EN
  localparam int PG_W   = 1;
`else
  localparam int PG_W   = 0;
`endif
  localparam int IDX_W  = LO_W + PG_W;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int RD_LAT = RD_LAT_BASE + OUT_REG;

  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [BANK_W-1:0] w_bank, r_bank, bank_sel;
  logic [IDX_W-1:0]  w_idx, r_idx;
  logic [DATA_W-1:0] bank_q [NB];
  logic [DATA_W-1:0] s1_data;
  logic              s1_vld;

  scope_fb_clear_fsm #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .CLEAR_VAL(CLEAR_VAL)
  ) u_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .mem_we  (m_we),
    .mem_addr(m_addr),
    .mem_data(m_data)
  );

  assign w_bank = m_addr[ADDR_W-1 -: BANK_W];
  assign r_bank = rd_addr[ADDR_W-1 -: BANK_W];

`ifdef SCOPE_FRAME_RAM_DBUF_EN
  logic swap_pend;

  // Page bit is the MSB of the in-bank index; reads latch the page at rd_en time.
  assign w_idx = {~front_page, m_addr[LO_W-1:0]};
  assign r_idx = {front_page, rd_addr[LO_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_page <= 1'b0;
      swap_pend  <= 1'b0;
    end else if (clr_busy) begin
      if (swap_req) swap_pend <= 1'b1;
    end else if (swap_req || swap_pend) begin
      front_page <= ~front_page;
      swap_pend  <= 1'b0;
    end
  end
`else
  assign w_idx = m_addr[LO_W-1:0];
  assign r_idx = rd_addr[LO_W-1:0];
`endif

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q;

    always_ff @(posedge clk) begin
      if (m_we && (w_bank == BANK_W'(b))) mem[w_idx] <= m_data;
    end

    // Separate block from the write so a same-edge collision reads old data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               q <= '0;
      else if (rd_en && (r_bank == BANK_W'(b))) q <= mem[r_idx];
    end

    assign bank_q[b] = q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel <= '0;
      s1_vld   <= 1'b0;
    end else begin
      // With an output register, stage 1 stays valid until rd_oce drains it.
      s1_vld <= rd_en | (s1_vld & ~rd_oce & (RD_LAT > RD_LAT_BASE));
      if (rd_en) bank_sel <= r_bank;
    end
  end

  assign s1_data = bank_q[bank_sel];

  if (RD_LAT > RD_LAT_BASE) begin : g_oreg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_oce & s1_vld;
        if (rd_oce) rd_data <= s1_data;
      end
    end
  end else begin : g_noreg
    assign rd_data  = s1_data;
    assign rd_valid = s1_vld;
  end

endmodule

// File: tb/tb_scope_frame_ram.sv
// Scoreboard bench: u0 = 8b x 32K, 2 banks, latency 1; u1 = 8b x 64, 4 banks, output register.
module tb_scope_frame_ram;

  localparam logic [7:0] CV1 = 8'h07;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n = 2'b11;
  logic [1:0]       wr_en = '0, rd_en = '0, rd_oce = 2'b11, clr_req = '0;
  logic [1:0][14:0] wr_addr = '0, rd_addr = '0;
  logic [1:0][7:0]  wr_data = '0;
  logic [1:0][7:0]  rd_data;
  logic [1:0]       rd_valid, clr_busy, clr_done;
`ifdef SCOPE_FRAME_RAM_DBUF_EN
  logic [1:0]       swap_req = '0, front_page;
`endif

  scope_frame_ram #(.DATA_W(8), .ADDR_W(15), .BANK_W(1), .OUT_REG(0), .CLEAR_VAL(8'h00)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .rd_en(rd_en[0]), .rd_oce(rd_oce[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .rd_valid(rd_valid[0]), .clr_req(clr_req[0]), .clr_busy(clr_busy[0]),
`ifdef SCOPE_FRAME_RAM_DBUF_EN
    .swap_req(swap_req[0]), .front_page(front_page[0]),
`endif
    .clr_done(clr_done[0]));

  scope_frame_ram #(.DATA_W(8), .ADDR_W(6), .BANK_W(2), .OUT_REG(1), .CLEAR_VAL(CV1)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1][5:0]), .wr_data(wr_data[1]),
    .rd_en(rd_en[1]), .rd_oce(rd_oce[1]), .rd_addr(rd_addr[1][5:0]), .rd_data(rd_data[1]),
    .rd_valid(rd_valid[1]), .clr_req(clr_req[1]), .clr_busy(clr_busy[1]),
`ifdef SCOPE_FRAME_RAM_DBUF_EN
    .swap_req(swap_req[1]), .front_page(front_page[1]),
`endif
    .clr_done(clr_done[1]));

  // Reference model: plain word arrays per instance and page, plus a "contents known" flag.
  logic [7:0] mdl   [2][2][32768];
  bit         known [2][2][32768];
  int         fp [2];

  typedef struct { logic [7:0] d; bit chk; int due; } exp_t;
  exp_t q0[$], q1[$];
  exp_t me;

  int checks = 0, failures = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int amask(input int u);
    return (u == 0) ? 32'h7FFF : 32'h3F;
  endfunction

  function automatic logic [7:0] cv(input int u);
    return (u == 0) ? 8'h00 : CV1;
  endfunction

  function automatic int rpage(input int u);
    return fp[u];
  endfunction

  function automatic int wpage(input int u);
`ifdef SCOPE_FRAME_RAM_DBUF_EN
    return 1 - fp[u];
`else
    return 0;
`endif
  endfunction

  task automatic push(input int u, input logic [7:0] d, input bit k, input int due);
    exp_t e;
    e.d = d; e.chk = k; e.due = due;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // One idle-FSM cycle: optional write and/or read; read sees pre-write contents.
  task automatic cycle(input int u, input bit we, input int wa, input logic [7:0] wd,
                       input bit re, input int ra, input int lat);
    int a_w, a_r;
    a_w = wa & amask(u);
    a_r = ra & amask(u);
    wr_en[u] = we; wr_addr[u] = 15'(a_w); wr_data[u] = wd;
    rd_en[u] = re; rd_addr[u] = 15'(a_r);
    if (re) push(u, mdl[u][rpage(u)][a_r], known[u][rpage(u)][a_r], cyc + lat);
    if (we) begin
      mdl[u][wpage(u)][a_w]   = wd;
      known[u][wpage(u)][a_w] = 1'b1;
    end
    tick();
    wr_en[u] = 1'b0;
    rd_en[u] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Full sweep; optionally pokes a write and a second clr_req mid-sweep, and a swap request.
  task automatic do_clear(input int u, input bit poke, input bit swp);
    int n, nb, nd, wp, nb_at_done, after;
    logic orig;
    n = amask(u) + 1; nb = 0; nd = 0; nb_at_done = -1; after = -1;
    wp = wpage(u);
    orig = 1'(fp[u]);
    clr_req[u] = 1'b1;
    tick();
    clr_req[u] = 1'b0;
    for (int i = 0; i < n + 4; i++) begin
      if (clr_busy[u]) nb++;
      if (clr_done[u]) begin nd++; nb_at_done = nb; after = i + 1; end
`ifdef SCOPE_FRAME_RAM_DBUF_EN
      if (swp && clr_done[u]) check($sformatf("swap_held_u%0d", u), front_page[u], orig);
      if (swp && i == after)  check($sformatf("swap_after_done_u%0d", u), front_page[u], ~orig);
      if (swp && i == 30) swap_req[u] = 1'b1;
`endif
      if (poke && i == 10) begin
        wr_en[u] = 1'b1; wr_addr[u] = '0; wr_data[u] = 8'h55; clr_req[u] = 1'b1;
      end
      tick();
      wr_en[u] = 1'b0; clr_req[u] = 1'b0;
`ifdef SCOPE_FRAME_RAM_DBUF_EN
      swap_req[u] = 1'b0;
`endif
    end
    check($sformatf("clr_busy_cycles_u%0d", u), nb, n);
    check($sformatf("clr_done_pulses_u%0d", u), nd, 1);
    check($sformatf("clr_done_timing_u%0d", u), nb_at_done, n);
    for (int a = 0; a < n; a++) begin
      mdl[u][wp][a]   = cv(u);
      known[u][wp][a] = 1'b1;
    end
    if (swp) fp[u] = 1 - fp[u];
  endtask

`ifdef SCOPE_FRAME_RAM_DBUF_EN
  task automatic swap(input int u);
    swap_req[u] = 1'b1;
    tick();
    swap_req[u] = 1'b0;
    fp[u] = 1 - fp[u];
    check($sformatf("front_page_u%0d", u), front_page[u], 1'(fp[u]));
  endtask
`endif

  // Monitor: pops the scoreboard whenever an instance presents rd_valid.
  always begin
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      if (rd_valid[u]) begin
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
          checks++; failures++;
          $display("FAIL unexpected_valid_u%0d: got rd_valid=1 expected no pending read", u);
        end else begin
          me = (u == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("rd_latency_u%0d", u), cyc, me.due);
          if (me.chk) check($sformatf("rd_data_u%0d", u), rd_data[u], me.d);
        end
      end
    end
  end

  initial begin
    int nb, nd, wp, wa, ra;
    logic [7:0] hold_exp;
    fp[0] = 0; fp[1] = 0;

    #2 rst_n = 2'b00;
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset_rd_data_u%0d", u), rd_data[u], 0);
      check($sformatf("reset_rd_valid_u%0d", u), rd_valid[u], 0);
      check($sformatf("reset_clr_busy_u%0d", u), clr_busy[u], 0);
      check($sformatf("reset_clr_done_u%0d", u), clr_done[u], 0);
`ifdef SCOPE_FRAME_RAM_DBUF_EN
      check($sformatf("reset_front_page_u%0d", u), front_page[u], 0);
`endif
    end
    idle(2);
    rst_n = 2'b11;
    tick();

    do_clear(0, 1'b1, 1'b0);
    do_clear(1, 1'b1, 1'b0);
`ifdef SCOPE_FRAME_RAM_DBUF_EN
    swap(0);
    swap(1);
    do_clear(1, 1'b0, 1'b0);
`endif

    // u0: basic r/w, bank boundary, hold, collision.
    cycle(0, 1, 15'h0000, 8'h01, 0, 0, 1);
    cycle(0, 1, 15'h7FFF, 8'h01, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 15'h0000, 1);
    cycle(0, 0, 0, 0, 1, 15'h7FFF, 1);
    cycle(0, 0, 0, 0, 1, 15'h4000, 1);
    cycle(0, 1, 15'h3FFF, 8'hA5, 0, 0, 1);
    cycle(0, 1, 15'h4000, 8'h5A, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 15'h3FFF, 1);
    hold_exp = mdl[0][rpage(0)][15'h4000];
    cycle(0, 0, 0, 0, 1, 15'h4000, 1);
    idle(2);
    if (known[0][rpage(0)][15'h4000]) check("rd_hold_u0", rd_data[0], hold_exp);
    cycle(0, 1, 15'h0100, 8'h11, 0, 0, 1);
    cycle(0, 1, 15'h0100, 8'hFF, 1, 15'h0100, 1);
    cycle(0, 0, 0, 0, 1, 15'h0100, 1);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: wa = 15'h0000; 1: wa = 15'h3FFF; 2: wa = 15'h4000; 3: wa = 15'h7FFF;
        default: wa = $urandom_range(0, 32767);
      endcase
      ra = ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, 32767));
      cycle(0, 1'($urandom_range(0, 1)), wa, 8'($urandom), 1'($urandom_range(0, 1)), ra, 1);
    end
    idle(3);

    // u1: output-register hold with rd_oce low, then release.
    cycle(1, 1, 6'h10, 8'h3C, 0, 0, 2);
    hold_exp = mdl[1][rpage(1)][6'h20];
    cycle(1, 0, 0, 0, 1, 6'h20, 2);
    idle(3);
    rd_oce[1] = 1'b0;
    cycle(1, 0, 0, 0, 1, 6'h10, 3);
    check("oce_low_valid_1", rd_valid[1], 0);
    check("oce_low_data_1", rd_data[1], hold_exp);
    tick();
    check("oce_low_valid_2", rd_valid[1], 0);
    check("oce_low_data_2", rd_data[1], hold_exp);
    rd_oce[1] = 1'b1;
    idle(3);

    for (int i = 0; i < 400; i++)
      cycle(1, 1'($urandom_range(0, 1)), $urandom_range(0, 63), 8'($urandom),
            1'($urandom_range(0, 1)), $urandom_range(0, 63), 2);
    for (int a = 0; a < 64; a++) cycle(1, 0, 0, 0, 1, a, 2);
    idle(4);

`ifdef SCOPE_FRAME_RAM_DBUF_EN
    cycle(1, 1, 6'h05, 8'h01, 1, 6'h05, 2);
    swap(1);
    cycle(1, 0, 0, 0, 1, 6'h05, 2);
    idle(4);
`endif

    // u1: reset in the middle of a sweep aborts it with no done pulse.
    wp = wpage(1);
    clr_req[1] = 1'b1;
    tick();
    clr_req[1] = 1'b0;
    idle(19);
    rst_n[1] = 1'b0;
    #1;
    check("midreset_busy", clr_busy[1], 0);
    check("midreset_done", clr_done[1], 0);
    check("midreset_rd_valid", rd_valid[1], 0);
    check("midreset_rd_data", rd_data[1], 0);
    fp[1] = 0;
    tick();
    rst_n[1] = 1'b1;
    nb = 0; nd = 0;
    repeat (80) begin
      tick();
      if (clr_busy[1]) nb++;
      if (clr_done[1]) nd++;
    end
    check("midreset_no_done", nd, 0);
    check("midreset_no_busy", nb, 0);
    for (int a = 0; a < 64; a++)
      if (mdl[1][wp][a] !== CV1) known[1][wp][a] = 1'b0;

`ifdef SCOPE_FRAME_RAM_DBUF_EN
    do_clear(1, 1'b1, 1'b1);
`else
    do_clear(1, 1'b1, 1'b0);
`endif
    for (int a = 0; a < 64; a++) cycle(1, 0, 0, 0, 1, a, 2);
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 0, 1, $urandom_range(0, 32767), 1);
    idle(5);

    check("sb_drain_u0", q0.size(), 0);
    check("sb_drain_u1", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
